// File: rtl/prsc_counter_pkg.sv
// Shared constants and packing helper for the prescaled counter bank.
// Optional macro: PRSC_COUNTER_OVF_FLAG_EN (sticky overflow flags, see prsc_counter_ch).
package prsc_counter_pkg;

    localparam int CLK_HZ = 40000000;

    // One count per second at the nominal system clock.
    localparam int DEF_PRSC_DIV = CLK_HZ;

    function automatic int f_ch_slice(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/prsc_counter_ch.sv
// One channel: prescaler, elapsed-time counter with wrap/saturate mode and tick pulse.
// Optional macro: PRSC_COUNTER_OVF_FLAG_EN adds the sticky ovf output.
module prsc_counter_ch
    import prsc_counter_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int PRSC_DIV = DEF_PRSC_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             sat,
`ifdef PRSC_COUNTER_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    localparam int                PRSC_W    = $clog2(PRSC_DIV);
    localparam logic [PRSC_W-1:0] PRSC_TERM = PRSC_W'(PRSC_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PRSC_W-1:0] prsc;
    logic [CNT_W-1:0]  cnt_next;
    logic              terminal;
    logic              at_max;

    assign terminal = (prsc == PRSC_TERM);
    assign at_max   = (cnt == CNT_MAX);

    // sat only matters on the cycle an increment is actually taken
    always_comb begin
        cnt_next = cnt + CNT_W'(1);
        if (at_max && sat) begin
            cnt_next = cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prsc <= '0;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            prsc <= '0;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (terminal) begin
                prsc <= '0;
                cnt  <= cnt_next;
                tick <= 1'b1;
            end else begin
                prsc <= prsc + PRSC_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef PRSC_COUNTER_OVF_FLAG_EN
    // Any increment taken from all-ones is either a wrap or a saturated attempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (en && terminal && at_max) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/prsc_counter_bank.sv
// Bank of NUM_CH independent prescaled counters with an atomic all-channel snapshot.
// Optional macro: PRSC_COUNTER_OVF_FLAG_EN adds o_ovf and o_snap_ovf.
module prsc_counter_bank
    import prsc_counter_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 16,
    parameter int PRSC_DIV = DEF_PRSC_DIV
) (
    input  logic                    i_clk,
    input  logic                    i_res_n,
    input  logic [NUM_CH-1:0]       i_cnt_en,
    input  logic [NUM_CH-1:0]       i_cnt_res,
    input  logic [NUM_CH-1:0]       i_sat,
    input  logic                    i_snap,
    output logic [NUM_CH*CNT_W-1:0] o_cnt,
    output logic [NUM_CH*CNT_W-1:0] o_snap,
    output logic                    o_snap_vld,
`ifdef PRSC_COUNTER_OVF_FLAG_EN
    output logic [NUM_CH-1:0]       o_ovf,
    output logic [NUM_CH-1:0]       o_snap_ovf,
`endif
    output logic [NUM_CH-1:0]       o_tick
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
`ifdef PRSC_COUNTER_OVF_FLAG_EN
        prsc_counter_ch #(
            .CNT_W    (CNT_W),
            .PRSC_DIV (PRSC_DIV)
        ) u_ch (
            .clk   (i_clk),
            .rst_n (i_res_n),
            .en    (i_cnt_en[k]),
            .clr   (i_cnt_res[k]),
            .sat   (i_sat[k]),
            .ovf   (o_ovf[k]),
            .cnt   (o_cnt[f_ch_slice(k, CNT_W) +: CNT_W]),
            .tick  (o_tick[k])
        );
`else
        prsc_counter_ch #(
            .CNT_W    (CNT_W),
            .PRSC_DIV (PRSC_DIV)
        ) u_ch (
            .clk   (i_clk),
            .rst_n (i_res_n),
            .en    (i_cnt_en[k]),
            .clr   (i_cnt_res[k]),
            .sat   (i_sat[k]),
            .cnt   (o_cnt[f_ch_slice(k, CNT_W) +: CNT_W]),
            .tick  (o_tick[k])
        );
`endif
    end

    // Capture the registered counters, so a same-cycle increment or clear is not seen.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            o_snap     <= '0;
            o_snap_vld <= 1'b0;
        end else begin
            o_snap_vld <= i_snap;
            if (i_snap) begin
                o_snap <= o_cnt;
            end
        end
    end

`ifdef PRSC_COUNTER_OVF_FLAG_EN
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            o_snap_ovf <= '0;
        end else if (i_snap) begin
            o_snap_ovf <= o_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_prsc_counter_bank.sv
// Directed bench for prsc_counter_bank with a reference model feeding an expected-value queue.
module tb_prsc_counter_bank;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 4;
    localparam int PRSC_DIV = 4;
    localparam int BW       = NUM_CH * CNT_W;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              res_n = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic [NUM_CH-1:0] clr = '0;
    logic [NUM_CH-1:0] sat = '0;
    logic              snap = 1'b0;
    logic [BW-1:0]     cnt;
    logic [BW-1:0]     snapv;
    logic              snap_vld;
    logic [NUM_CH-1:0] tick;
`ifdef PRSC_COUNTER_OVF_FLAG_EN
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] snap_ovf;
`endif

    prsc_counter_bank #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .PRSC_DIV (PRSC_DIV)
    ) dut (
        .i_clk      (clk),
        .i_res_n    (res_n),
        .i_cnt_en   (en),
        .i_cnt_res  (clr),
        .i_sat      (sat),
        .i_snap     (snap),
        .o_cnt      (cnt),
        .o_snap     (snapv),
        .o_snap_vld (snap_vld),
`ifdef PRSC_COUNTER_OVF_FLAG_EN
        .o_ovf      (ovf),
        .o_snap_ovf (snap_ovf),
`endif
        .o_tick     (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BW-1:0]     cnt;
        logic [NUM_CH-1:0] tick;
        logic [BW-1:0]     snap;
        logic              vld;
`ifdef PRSC_COUNTER_OVF_FLAG_EN
        logic [NUM_CH-1:0] ovf;
        logic [NUM_CH-1:0] sovf;
`endif
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    int                m_prsc[NUM_CH];
    int                m_cnt[NUM_CH];
    int                tc[NUM_CH];
    logic [NUM_CH-1:0] m_tick;
    logic [BW-1:0]     m_snap;
    logic              m_vld;
`ifdef PRSC_COUNTER_OVF_FLAG_EN
    logic [NUM_CH-1:0] m_ovf;
    logic [NUM_CH-1:0] m_sovf;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BW-1:0] pack_cnt();
        logic [BW-1:0] r;
        for (int k = 0; k < NUM_CH; k++) begin
            r[k*CNT_W +: CNT_W] = m_cnt[k][CNT_W-1:0];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_prsc[k] = 0;
            m_cnt[k]  = 0;
        end
        m_tick = '0;
        m_snap = '0;
        m_vld  = 1'b0;
`ifdef PRSC_COUNTER_OVF_FLAG_EN
        m_ovf  = '0;
        m_sovf = '0;
`endif
    endtask

    task automatic step(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] c,
                        input logic [NUM_CH-1:0] s, input logic sn);
        exp_t x;
        en   = e;
        clr  = c;
        sat  = s;
        snap = sn;
        if (sn) begin
            m_snap = pack_cnt();
`ifdef PRSC_COUNTER_OVF_FLAG_EN
            m_sovf = m_ovf;
`endif
        end
        m_vld = sn;
        for (int k = 0; k < NUM_CH; k++) begin
            if (c[k]) begin
                m_prsc[k] = 0;
                m_cnt[k]  = 0;
                m_tick[k] = 1'b0;
`ifdef PRSC_COUNTER_OVF_FLAG_EN
                m_ovf[k]  = 1'b0;
`endif
            end else if (e[k]) begin
                if (m_prsc[k] == PRSC_DIV - 1) begin
                    m_prsc[k] = 0;
                    m_tick[k] = 1'b1;
                    if (m_cnt[k] == CNT_MAX) begin
`ifdef PRSC_COUNTER_OVF_FLAG_EN
                        m_ovf[k] = 1'b1;
`endif
                        if (!s[k]) m_cnt[k] = 0;
                    end else begin
                        m_cnt[k]++;
                    end
                end else begin
                    m_prsc[k]++;
                    m_tick[k] = 1'b0;
                end
            end else begin
                m_tick[k] = 1'b0;
            end
        end
        x.cnt  = pack_cnt();
        x.tick = m_tick;
        x.snap = m_snap;
        x.vld  = m_vld;
`ifdef PRSC_COUNTER_OVF_FLAG_EN
        x.ovf  = m_ovf;
        x.sovf = m_sovf;
`endif
        q.push_back(x);

        @(posedge clk);
        #1;
        x = q.pop_front();
        chk("sb_cnt", 32'(cnt), 32'(x.cnt));
        chk("sb_tick", 32'(tick), 32'(x.tick));
        chk("sb_snap", 32'(snapv), 32'(x.snap));
        chk("sb_snap_vld", 32'(snap_vld), 32'(x.vld));
`ifdef PRSC_COUNTER_OVF_FLAG_EN
        chk("sb_ovf", 32'(ovf), 32'(x.ovf));
        chk("sb_snap_ovf", 32'(snap_ovf), 32'(x.sovf));
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            tc[k] += int'(tick[k]);
        end
    endtask

    task automatic clear_ticks();
        for (int k = 0; k < NUM_CH; k++) tc[k] = 0;
    endtask

    initial begin
        model_reset();
        clear_ticks();
        res_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_snap", 32'(snapv), 32'd0);
        chk("rst_vld", 32'(snap_vld), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        #2 res_n = 1'b1;

        // ch0 alone for 16 cycles
        repeat (16) step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t1_cnt0", 32'(cnt[3:0]), 32'd4);
        chk("t1_ticks0", 32'(tc[0]), 32'd4);
        chk("t1_cnt1", 32'(cnt[7:4]), 32'd0);

        // ch0 wraps, ch1 saturates
        step(2'b00, 2'b11, 2'b00, 1'b0);
        clear_ticks();
        repeat (60) step(2'b11, 2'b00, 2'b10, 1'b0);
        chk("t2_cnt0_max", 32'(cnt[3:0]), 32'd15);
        chk("t2_cnt1_max", 32'(cnt[7:4]), 32'd15);
        repeat (4) step(2'b11, 2'b00, 2'b10, 1'b0);
        chk("t2_cnt0_wrap", 32'(cnt[3:0]), 32'd0);
        chk("t2_cnt1_sat", 32'(cnt[7:4]), 32'd15);
`ifdef PRSC_COUNTER_OVF_FLAG_EN
        chk("t2_ovf", 32'(ovf), 32'd3);
`endif
        repeat (16) step(2'b10, 2'b00, 2'b10, 1'b0);
        chk("t2_cnt1_hold", 32'(cnt[7:4]), 32'd15);
        chk("t2_ticks1", 32'(tc[1]), 32'd20);
        chk("t2_cnt0_paused", 32'(cnt[3:0]), 32'd0);

        // pause keeps the partial prescaler period
        step(2'b01, 2'b01, 2'b00, 1'b0);
        chk("t3_clr_over_en", 32'(cnt[3:0]), 32'd0);
        repeat (6) step(2'b01, 2'b00, 2'b00, 1'b0);
        repeat (10) step(2'b00, 2'b00, 2'b00, 1'b0);
        repeat (2) step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t3_pause_cnt", 32'(cnt[3:0]), 32'd2);
        step(2'b01, 2'b01, 2'b00, 1'b0);
        chk("t3_clr_cnt", 32'(cnt[3:0]), 32'd0);
        chk("t3_clr_tick", 32'(tick[0]), 32'd0);

        // snapshot on the 2->3 increment
        repeat (11) step(2'b01, 2'b00, 2'b00, 1'b0);
        step(2'b01, 2'b00, 2'b00, 1'b1);
        chk("t4_snap0", 32'(snapv[3:0]), 32'd2);
        chk("t4_vld", 32'(snap_vld), 32'd1);
        chk("t4_cnt0", 32'(cnt[3:0]), 32'd3);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t4_vld_drop", 32'(snap_vld), 32'd0);
        repeat (5) step(2'b01, 2'b00, 2'b00, 1'b1);
        step(2'b01, 2'b01, 2'b00, 1'b1);
        chk("t4_snap_preclr", 32'(snapv[3:0]), 32'd4);
        step(2'b00, 2'b00, 2'b00, 1'b0);

        // async reset between edges
        repeat (6) step(2'b11, 2'b00, 2'b00, 1'b0);
        #2 res_n = 1'b0;
        #1;
        chk("t5_rst_cnt", 32'(cnt), 32'd0);
        chk("t5_rst_snap", 32'(snapv), 32'd0);
        chk("t5_rst_vld", 32'(snap_vld), 32'd0);
        chk("t5_rst_tick", 32'(tick), 32'd0);
        model_reset();
        @(posedge clk);
        #2 res_n = 1'b1;
        repeat (3) step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t5_not_yet", 32'(cnt[3:0]), 32'd0);
        step(2'b01, 2'b00, 2'b00, 1'b0);
        chk("t5_first_inc", 32'(cnt[3:0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prsc_counter_bank.md
Name: prsc_counter_bank

Overview:
- Parametrised successor of the single-channel test counter for the slave CPLD.
- Holds NUM_CH independent prescaled elapsed-time counters, each with its own enable, synchronous clear, and wrap or saturate mode.
- An atomic snapshot of all channels is taken on request.
- Sits between the link/status logic and the SFP test/diagnostic readout.

Parameters:
- NUM_CH, 2, number of independent counter channels (1..8).
- CNT_W, 16, counter width per channel in bits.
- PRSC_DIV, 40000000, clock cycles per count increment (1 s at 40 MHz); must be ≥ 2.
- PRSC_W, $clog2(PRSC_DIV), prescaler width (derived localparam, not overridable).

Ports:
- i_clk  in  1  system clock.
- i_res_n  in  1  asynchronous active-low reset.
- i_cnt_en  in  NUM_CH  per-channel count enable (level).
- i_cnt_res  in  NUM_CH  per-channel synchronous clear (level).
- i_sat  in  NUM_CH  per-channel mode: 1 = saturate at all-ones, 0 = wrap to 0.
- i_snap  in  1  snapshot request (single-cycle pulse).
- o_cnt  out  NUM_CH*CNT_W  live counters; channel k at [k*CNT_W +: CNT_W].
- o_snap  out  NUM_CH*CNT_W  snapshot register, same packing as o_cnt.
- o_snap_vld  out  1  one-cycle pulse, o_snap updated.
- o_tick  out  NUM_CH  one-cycle pulse per channel on each prescaler terminal count.

Behaviour:
- Reset: async, while i_res_n low. All prescalers, o_cnt, o_snap, o_snap_vld and o_tick are 0. Asserting reset mid-count discards all state; no partial snapshot survives.
- Per-channel prescaler r_prsc[k], PRSC_W bits. Terminal when r_prsc[k] == PRSC_DIV-1.
- Priority per channel per cycle: i_cnt_res > i_cnt_en > hold.
  - i_cnt_res=1: r_prsc[k]←0, cnt[k]←0, o_tick[k]←0, regardless of i_cnt_en.
  - i_cnt_en=1, not terminal: r_prsc[k]+1.
  - i_cnt_en=1, terminal: r_prsc[k]←0, o_tick[k]←1 for that cycle only, and cnt[k] is incremented.
  - i_cnt_en=0: prescaler and counter hold (pause, not clear). Re-enable resumes the partial period.
- Increment rules:
  - Mode wrap (i_sat[k]=0): all-ones → 0.
  - Mode saturate (i_sat[k]=1): cnt stays at all-ones; prescaler keeps cycling and o_tick still pulses.
  - i_sat is sampled on the incrementing cycle only. Switching mode while the counter is saturated has no retroactive effect.
- Timing: first increment lands exactly PRSC_DIV enabled cycles after clear. o_cnt is registered and changes the cycle after terminal.
- Snapshot:
  - i_snap high in cycle T captures every channel's o_cnt value as registered at T, i.e. before any same-cycle increment or clear. o_snap is valid from T+1 with o_snap_vld=1 at T+1 only.
  - Back-to-back i_snap on consecutive cycles gives consecutive captures and a continuous o_snap_vld.
  - i_snap coincident with i_cnt_res captures the pre-clear value.
- Channels are fully independent; no cross-channel arbitration.

Optional Feature:
- Macro: PRSC_COUNTER_OVF_FLAG_EN
- Defined:
  - Adds output o_ovf [NUM_CH], a sticky per-channel flag, reset 0.
  - Set on a wrap event (all-ones → 0 in wrap mode) or on an increment attempted while saturated.
  - Cleared only by that channel's i_cnt_res or by reset.
  - A set and a clear in the same cycle resolve to clear.
  - o_ovf is also captured into o_snap_ovf [NUM_CH] alongside o_snap.
- Undefined: neither port exists, no flag registers are built; all other behaviour is identical.

Decomposition:
- Shared package prsc_counter_pkg holds:
  - localparam CLK_HZ = 40000000;
  - default PRSC_DIV;
  - function f_ch_slice(k, w) returning the base bit index for flat-bus packing.
- One sub-module, prsc_counter_ch: a single channel (prescaler, counter, mode, tick, optional ovf). The bank instantiates it NUM_CH times in a generate loop and owns only the snapshot register and o_snap_vld.

Test Plan (PRSC_DIV=4, CNT_W=4, NUM_CH=2 unless noted):
- Enable ch0 only for 16 cycles from reset → o_cnt[3:0]=4; o_tick[0] pulses at cycles 4, 8, 12, 16; ch1 stays 0.
- ch0 in wrap mode, enable 64 cycles → counts reach 15 then 0 at the 16th tick; with PRSC_COUNTER_OVF_FLAG_EN, o_ovf[0] sets on that cycle and holds.
- ch1 in saturate mode, enable 80 cycles → o_cnt[7:4] stays 15 after the 60th cycle; o_tick[1] keeps pulsing.
- Enable 6 cycles, disable 10, enable 2 → exactly 2 increments (partial period preserved); assert i_cnt_res with i_cnt_en=1 → counter and prescaler 0 next cycle.
- Pulse i_snap on the same cycle ch0 increments 2→3 → o_snap[3:0]=2, o_snap_vld=1 for exactly one cycle; o_cnt[3:0]=3.
- Drop i_res_n asynchronously mid-count (between clock edges) → all outputs 0 immediately; after release, first increment comes exactly PRSC_DIV enabled cycles later.
